pipe_hazard_ctrl: RTL and testbench

- Central stall/flush controller for the 5-stage MIPS pipeline.
- Drives the enable and flush inputs of PC, IF/ID, ID/EX, EX/MEM and MEM/WB.
- Detects load-use hazards at ID and applies branch/jump redirect flushes resolved at the EX/MEM register.
- Sequences a req/ready handshake to data memory, freezing the pipe on wait states; keeps saturating stall/flush statistics.

---
 rtl/pipe_hazard_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Purpose : central stall/flush controller for the 5-stage MIPS pipeline (load-use, redirect, dmem wait).
// Latency : enables/flushes/dmem_req are combinational from state and inputs; state and counters update on negedge CLK.
// Backpressure: dmem_ready low freezes every pipe register until the access completes or the timeout halts the pipe.
//
// Ports:
//   CLK, RSTn                     pipeline clock (negedge active), async active-low reset
//   id_rs/id_rt/id_use_rs/_rt     source registers of the instruction sitting in IF/ID
//   idex_memread, idex_wreg       load-in-EX detection for the load-use check
//   exmem_memread/_memwrite       data memory access in MEM
//   exmem_pcsrc, exmem_jtopc      branch/jump redirect resolved at EX/MEM
//   dmem_ready / dmem_req         data memory handshake
//   *_en, *_flush                 per-register enable and bubble-insert controls
//   halted                        sticky memory-timeout flag (cleared only by reset)
//   stall_cnt, flush_cnt          saturating statistics
module pipe_hazard_ctrl #(
  parameter int unsigned TIMEOUT_CYC = 64,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             CLK,
  input  logic             RSTn,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             idex_memread,
  input  logic [4:0]       idex_wreg,
  input  logic             exmem_memread,
  input  logic             exmem_memwrite,
  input  logic             exmem_pcsrc,
  input  logic             exmem_jtopc,
  input  logic             dmem_ready,
  output logic             dmem_req,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  // Wait counter is wide enough to reach TIMEOUT_CYC; with the timeout
  // disabled it simply saturates.
  localparam int unsigned    WCW       = $clog2(TIMEOUT_CYC + 2);
  localparam logic [WCW-1:0] TIMEOUT_W = WCW'(TIMEOUT_CYC);
  localparam bit             TO_EN     = (TIMEOUT_CYC != 0);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_HALT     = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WCW-1:0]   wait_cnt_q, wait_cnt_d;
  logic             halted_q, halted_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic mem_acc;
  logic redirect;
  logic lu;

  // Ungated control decisions; reset forcing is applied at the outputs.
  logic pc_en_c, ifid_en_c, idex_en_c, exmem_en_c, memwb_en_c;
  logic ifid_flush_c, idex_flush_c, exmem_flush_c;
  logic dmem_req_c;
  logic mem_stall;   // memory freeze this cycle
  logic issue;       // pipe is moving: redirect/load-use are evaluated

  assign mem_acc  = exmem_memread | exmem_memwrite;
  assign redirect = exmem_pcsrc | exmem_jtopc;

  // r0 never carries a real dependency, so a load to r0 never stalls.
  assign lu = idex_memread && (idex_wreg != 5'd0) &&
              ((id_use_rs && (id_rs == idex_wreg)) ||
               (id_use_rt && (id_rt == idex_wreg)));

  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    halted_d      = halted_q;
    stall_cnt_d   = stall_cnt_q;
    flush_cnt_d   = flush_cnt_q;
    pc_en_c       = 1'b1;
    ifid_en_c     = 1'b1;
    idex_en_c     = 1'b1;
    exmem_en_c    = 1'b1;
    memwb_en_c    = 1'b1;
    ifid_flush_c  = 1'b0;
    idex_flush_c  = 1'b0;
    exmem_flush_c = 1'b0;
    dmem_req_c    = 1'b0;
    mem_stall     = 1'b0;
    issue         = 1'b0;

    case (state_q)
      ST_RUN: begin
        dmem_req_c = mem_acc;
        if (mem_acc && !dmem_ready) begin
          // Any redirect in EX/MEM stays there (frozen) and is applied on release.
          mem_stall  = 1'b1;
          state_d    = ST_MEM_WAIT;
          wait_cnt_d = WCW'(1);
        end else begin
          issue = 1'b1;
        end
      end

      ST_MEM_WAIT: begin
        dmem_req_c = 1'b1;
        if (dmem_ready) begin
          // Release cycle behaves as a zero-wait access in RUN.
          issue      = 1'b1;
          state_d    = ST_RUN;
          wait_cnt_d = '0;
        end else begin
          mem_stall = 1'b1;
          if (wait_cnt_q != {WCW{1'b1}}) begin
            wait_cnt_d = wait_cnt_q + 1'b1;
          end
          if (TO_EN && (wait_cnt_q == TIMEOUT_W)) begin
            state_d  = ST_HALT;
            halted_d = 1'b1;
          end
        end
      end

      ST_HALT: begin
        pc_en_c    = 1'b0;
        ifid_en_c  = 1'b0;
        idex_en_c  = 1'b0;
        exmem_en_c = 1'b0;
        memwb_en_c = 1'b0;
      end

      default: begin
        state_d = ST_RUN;
      end
    endcase

    if (mem_stall) begin
      pc_en_c    = 1'b0;
      ifid_en_c  = 1'b0;
      idex_en_c  = 1'b0;
      exmem_en_c = 1'b0;
      memwb_en_c = 1'b0;
    end else if (issue && redirect) begin
      // The wrong-path instructions in IF/ID, ID/EX and EX/MEM are squashed;
      // the ID instruction is discarded so its load-use stall is moot.
      ifid_flush_c  = 1'b1;
      idex_flush_c  = 1'b1;
      exmem_flush_c = 1'b1;
    end else if (issue && lu) begin
      // Hold PC and IF/ID one cycle, push a bubble into EX.
      pc_en_c      = 1'b0;
      ifid_en_c    = 1'b0;
      idex_flush_c = 1'b1;
    end

    if ((state_q != ST_HALT) && !pc_en_c && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
    if (ifid_flush_c && (flush_cnt_q != {CNT_W{1'b1}})) begin
      flush_cnt_d = flush_cnt_q + 1'b1;
    end
  end

  always_ff @(negedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q     <= ST_RUN;
      wait_cnt_q  <= '0;
      halted_q    <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      halted_q    <= halted_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // While reset is held the pipe registers must be free to load their reset
  // values, and any outstanding memory request is dropped immediately.
  assign pc_en       = pc_en_c    | ~RSTn;
  assign ifid_en     = ifid_en_c  | ~RSTn;
  assign idex_en     = idex_en_c  | ~RSTn;
  assign exmem_en    = exmem_en_c | ~RSTn;
  assign memwb_en    = memwb_en_c | ~RSTn;
  assign ifid_flush  = ifid_flush_c  & RSTn;
  assign idex_flush  = idex_flush_c  & RSTn;
  assign exmem_flush = exmem_flush_c & RSTn;
  assign dmem_req    = dmem_req_c    & RSTn;
  assign halted      = halted_q;
  assign stall_cnt   = stall_cnt_q;
  assign flush_cnt   = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Purpose : self-checking bench for pipe_hazard_ctrl; two instances share stimulus
//           (timeout 4 / 16-bit counters, and timeout disabled / 2-bit counters).
// Latency : inputs driven 1 time unit after negedge, outputs sampled 1 unit after posedge.
module tb_pipe_hazard_ctrl;

  logic       CLK = 1'b1;
  logic       RSTn;
  logic [4:0] id_rs, id_rt, idex_wreg;
  logic       id_use_rs, id_use_rt, idex_memread;
  logic       exmem_memread, exmem_memwrite, exmem_pcsrc, exmem_jtopc, dmem_ready;

  logic [1:0] dmem_req, pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic [1:0] ifid_flush, idex_flush, exmem_flush, halted;
  logic [15:0] stall_cnt0, flush_cnt0;
  logic [1:0]  stall_cnt1, flush_cnt1;

  int checks   = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  pipe_hazard_ctrl #(.TIMEOUT_CYC(4), .CNT_W(16)) u_dut0 (
    .CLK(CLK), .RSTn(RSTn), .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs),
    .id_use_rt(id_use_rt), .idex_memread(idex_memread), .idex_wreg(idex_wreg),
    .exmem_memread(exmem_memread), .exmem_memwrite(exmem_memwrite),
    .exmem_pcsrc(exmem_pcsrc), .exmem_jtopc(exmem_jtopc), .dmem_ready(dmem_ready),
    .dmem_req(dmem_req[0]), .pc_en(pc_en[0]), .ifid_en(ifid_en[0]), .idex_en(idex_en[0]),
    .exmem_en(exmem_en[0]), .memwb_en(memwb_en[0]), .ifid_flush(ifid_flush[0]),
    .idex_flush(idex_flush[0]), .exmem_flush(exmem_flush[0]), .halted(halted[0]),
    .stall_cnt(stall_cnt0), .flush_cnt(flush_cnt0));

  pipe_hazard_ctrl #(.TIMEOUT_CYC(0), .CNT_W(2)) u_dut1 (
    .CLK(CLK), .RSTn(RSTn), .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs),
    .id_use_rt(id_use_rt), .idex_memread(idex_memread), .idex_wreg(idex_wreg),
    .exmem_memread(exmem_memread), .exmem_memwrite(exmem_memwrite),
    .exmem_pcsrc(exmem_pcsrc), .exmem_jtopc(exmem_jtopc), .dmem_ready(dmem_ready),
    .dmem_req(dmem_req[1]), .pc_en(pc_en[1]), .ifid_en(ifid_en[1]), .idex_en(idex_en[1]),
    .exmem_en(exmem_en[1]), .memwb_en(memwb_en[1]), .ifid_flush(ifid_flush[1]),
    .idex_flush(idex_flush[1]), .exmem_flush(exmem_flush[1]), .halted(halted[1]),
    .stall_cnt(stall_cnt1), .flush_cnt(flush_cnt1));

  // ---------------- reference model ----------------
  // Control vector layout: {pc,ifid,idex,exmem,memwb enables, ifid/idex/exmem flush, dmem_req, halted}
  int TO[2]   = '{4, 0};
  int MAXC[2] = '{65535, 3};
  bit m_wait[2];
  bit m_halt[2];
  int m_wcnt[2];
  int m_stall[2];
  int m_flush[2];

  function automatic logic [9:0] act(int k);
    return {pc_en[k], ifid_en[k], idex_en[k], exmem_en[k], memwb_en[k],
            ifid_flush[k], idex_flush[k], exmem_flush[k], dmem_req[k], halted[k]};
  endfunction

  function automatic logic [15:0] act_stall(int k);
    return (k == 0) ? stall_cnt0 : {14'b0, stall_cnt1};
  endfunction

  function automatic logic [15:0] act_flush(int k);
    return (k == 0) ? flush_cnt0 : {14'b0, flush_cnt1};
  endfunction

  function automatic logic [9:0] exp_ctl(int k);
    bit acc, redir, hz, req;
    acc   = exmem_memread || exmem_memwrite;
    redir = exmem_pcsrc || exmem_jtopc;
    hz    = idex_memread && (idex_wreg != 0) &&
            ((id_use_rs && id_rs == idex_wreg) || (id_use_rt && id_rt == idex_wreg));
    if (!RSTn)                              return 10'b11111_000_0_0;
    if (m_halt[k])                          return 10'b00000_000_0_1;
    if (!dmem_ready && (acc || m_wait[k]))  return 10'b00000_000_1_0;
    req = acc || m_wait[k];
    if (redir) return {8'b11111_111, req, 1'b0};
    if (hz)    return {8'b00111_010, req, 1'b0};
    return {8'b11111_000, req, 1'b0};
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_wait[k] = 0; m_halt[k] = 0; m_wcnt[k] = 0; m_stall[k] = 0; m_flush[k] = 0;
    end
  endtask

  task automatic model_tick();
    logic [9:0] e;
    for (int k = 0; k < 2; k++) begin
      e = exp_ctl(k);
      if (!RSTn) begin
        m_wait[k] = 0; m_halt[k] = 0; m_wcnt[k] = 0; m_stall[k] = 0; m_flush[k] = 0;
      end else if (!m_halt[k]) begin
        if (!e[9] && m_stall[k] < MAXC[k]) m_stall[k]++;
        if (e[4] && m_flush[k] < MAXC[k])  m_flush[k]++;
        if (e[9:5] == 5'b0) begin
          if (!m_wait[k]) begin
            m_wait[k] = 1; m_wcnt[k] = 1;
          end else if (TO[k] != 0 && m_wcnt[k] == TO[k]) begin
            m_halt[k] = 1; m_wait[k] = 0;
          end else begin
            m_wcnt[k]++;
          end
        end else begin
          m_wait[k] = 0; m_wcnt[k] = 0;
        end
      end
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic mid();
    @(posedge CLK); #1;
  endtask

  task automatic tick();
    @(negedge CLK);
    model_tick();
    #1;
  endtask

  task automatic clear_inputs();
    id_rs = 0; id_rt = 0; id_use_rs = 0; id_use_rt = 0; idex_memread = 0; idex_wreg = 0;
    exmem_memread = 0; exmem_memwrite = 0; exmem_pcsrc = 0; exmem_jtopc = 0; dmem_ready = 1;
  endtask

  task automatic do_reset();
    RSTn = 0;
    model_reset();
    clear_inputs();
    tick();
    tick();
    RSTn = 1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    RSTn = 0;
    model_reset();
    clear_inputs();
    exmem_memread = 1; dmem_ready = 0; exmem_pcsrc = 1;
    idex_memread = 1; idex_wreg = 3; id_rs = 3; id_use_rs = 1;
    #2;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (act(k) !== 10'b11111_000_0_0) begin
        failures++; $display("FAIL reset_ctl dut%0d act=%b exp=%b", k, act(k), 10'b11111_000_0_0);
      end
    end
    tick();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (act_stall(k) !== 16'd0 || act_flush(k) !== 16'd0 || halted[k] !== 1'b0) begin
        failures++; $display("FAIL reset_state dut%0d stall=%0d flush=%0d halted=%b exp 0/0/0",
                             k, act_stall(k), act_flush(k), halted[k]);
      end
    end
    clear_inputs();
    tick();
    RSTn = 1;
  endtask

  task automatic test_load_use();
    do_reset();
    idex_memread = 1; idex_wreg = 5; id_rs = 5; id_use_rs = 1; id_rt = 7; id_use_rt = 1;
    mid();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (act(k) !== 10'b00111_010_0_0) begin
        failures++; $display("FAIL lu_stall dut%0d act=%b exp=%b", k, act(k), 10'b00111_010_0_0);
      end
    end
    tick();
    idex_memread = 0;  // bubble now in ID/EX
    mid();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (act(k) !== 10'b11111_000_0_0 || act_stall(k) !== 16'd1) begin
        failures++; $display("FAIL lu_release dut%0d act=%b stall=%0d exp=%b stall=1",
                             k, act(k), act_stall(k), 10'b11111_000_0_0);
      end
    end
    tick();
    idex_memread = 1; idex_wreg = 0; id_rs = 0; id_use_rs = 1;
    mid();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (act(k) !== 10'b11111_000_0_0) begin
        failures++; $display("FAIL lu_r0 dut%0d act=%b exp=%b", k, act(k), 10'b11111_000_0_0);
      end
    end
    tick();
    idex_wreg = 9; id_rs = 3; id_rt = 9; id_use_rs = 1; id_use_rt = 1;
    mid();
    checks++;
    if (act(0) !== 10'b00111_010_0_0) begin
      failures++; $display("FAIL lu_rt act=%b exp=%b", act(0), 10'b00111_010_0_0);
    end
    tick();
    id_use_rt = 0;
    mid();
    checks++;
    if (act(0) !== 10'b11111_000_0_0 || act_stall(0) !== 16'd2) begin
      failures++; $display("FAIL lu_rt_unused act=%b stall=%0d exp=%b stall=2",
                           act(0), act_stall(0), 10'b11111_000_0_0);
    end
    tick();
  endtask

  task automatic test_redirect();
    do_reset();
    exmem_pcsrc = 1;
    idex_memread = 1; idex_wreg = 5; id_rs = 5; id_use_rs = 1;
    mid();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (act(k) !== 10'b11111_111_0_0) begin
        failures++; $display("FAIL redirect_ctl dut%0d act=%b exp=%b", k, act(k), 10'b11111_111_0_0);
      end
    end
    tick();
    clear_inputs();
    exmem_jtopc = 1;
    mid();
    checks++;
    if (act_flush(0) !== 16'd1 || act_stall(0) !== 16'd0 || act(0) !== 10'b11111_111_0_0) begin
      failures++; $display("FAIL redirect_cnt flush=%0d stall=%0d act=%b exp flush=1 stall=0 act=%b",
                           act_flush(0), act_stall(0), act(0), 10'b11111_111_0_0);
    end
    tick();
    clear_inputs();
    mid();
    checks++;
    if (act_flush(0) !== 16'd2) begin
      failures++; $display("FAIL jump_cnt flush=%0d exp=2", act_flush(0));
    end
  endtask

  task automatic test_mem_wait();
    do_reset();
    exmem_memread = 1; dmem_ready = 0; exmem_pcsrc = 1;
    for (int i = 0; i < 3; i++) begin
      mid();
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (act(k) !== 10'b00000_000_1_0) begin
          failures++; $display("FAIL memwait_c%0d dut%0d act=%b exp=%b", i, k, act(k), 10'b00000_000_1_0);
        end
      end
      tick();
    end
    dmem_ready = 1;
    mid();
    // Held redirect is applied on the release cycle.
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (act(k) !== 10'b11111_111_1_0) begin
        failures++; $display("FAIL memwait_release dut%0d act=%b exp=%b", k, act(k), 10'b11111_111_1_0);
      end
    end
    tick();
    clear_inputs();
    mid();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (act(k) !== 10'b11111_000_0_0 || act_stall(k) !== 16'd3 || act_flush(k) !== 16'd1) begin
        failures++; $display("FAIL memwait_after dut%0d act=%b stall=%0d flush=%0d exp=%b stall=3 flush=1",
                             k, act(k), act_stall(k), act_flush(k), 10'b11111_000_0_0);
      end
    end
    tick();
  endtask

  task automatic test_timeout();
    do_reset();
    exmem_memwrite = 1; dmem_ready = 0;
    for (int i = 0; i < 5; i++) begin
      mid();
      checks++;
      if (act(0) !== 10'b00000_000_1_0) begin
        failures++; $display("FAIL timeout_wait_c%0d act=%b exp=%b", i, act(0), 10'b00000_000_1_0);
      end
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      mid();
      checks++;
      if (act(0) !== 10'b00000_000_0_1 || act_stall(0) !== 16'd5) begin
        failures++; $display("FAIL timeout_halt_c%0d act=%b stall=%0d exp=%b stall=5",
                             i, act(0), act_stall(0), 10'b00000_000_0_1);
      end
      checks++;
      if (act(1) !== 10'b00000_000_1_0 || act_stall(1) !== 16'd3) begin
        failures++; $display("FAIL notimeout_c%0d act=%b stall=%0d exp=%b stall=3",
                             i, act(1), act_stall(1), 10'b00000_000_1_0);
      end
      tick();
    end
    clear_inputs();
    mid();
    checks++;
    if (act(0) !== 10'b00000_000_0_1) begin
      failures++; $display("FAIL halt_sticky act=%b exp=%b", act(0), 10'b00000_000_0_1);
    end
    RSTn = 0;
    model_reset();
    #1;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (act(k) !== 10'b11111_000_0_0 || act_stall(k) !== 16'd0 || act_flush(k) !== 16'd0) begin
        failures++; $display("FAIL halt_reset dut%0d act=%b stall=%0d flush=%0d exp=%b 0 0",
                             k, act(k), act_stall(k), act_flush(k), 10'b11111_000_0_0);
      end
    end
    tick();
    RSTn = 1;
  endtask

  task automatic test_reset_midwait();
    do_reset();
    exmem_memread = 1; dmem_ready = 0;
    mid(); tick();
    mid(); tick();
    mid();
    RSTn = 0;
    model_reset();
    #1;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (act(k) !== 10'b11111_000_0_0 || act_stall(k) !== 16'd0) begin
        failures++; $display("FAIL reset_midwait dut%0d act=%b stall=%0d exp=%b stall=0",
                             k, act(k), act_stall(k), 10'b11111_000_0_0);
      end
    end
    tick();
    RSTn = 1;
    clear_inputs();
    exmem_memread = 1;
    mid();
    checks++;
    if (act(0) !== 10'b11111_000_1_0) begin
      failures++; $display("FAIL after_midwait act=%b exp=%b", act(0), 10'b11111_000_1_0);
    end
    tick();
  endtask

  task automatic test_saturate();
    do_reset();
    exmem_pcsrc = 1;
    for (int i = 0; i < 5; i++) begin
      mid(); tick();
    end
    clear_inputs();
    mid();
    checks++;
    if (act_flush(1) !== 16'd3 || act_flush(0) !== 16'd5) begin
      failures++; $display("FAIL flush_saturate dut1=%0d dut0=%0d exp 3 and 5", act_flush(1), act_flush(0));
    end
    tick();
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 600; n++) begin
      RSTn           = !(($urandom_range(0, 59) == 0) || (m_halt[0] && $urandom_range(0, 3) == 0));
      id_rs          = 5'($urandom_range(0, 3));
      id_rt          = 5'($urandom_range(0, 3));
      id_use_rs      = 1'($urandom);
      id_use_rt      = 1'($urandom);
      idex_memread   = ($urandom_range(0, 2) == 0);
      idex_wreg      = 5'($urandom_range(0, 3));
      exmem_memread  = ($urandom_range(0, 3) == 0);
      exmem_memwrite = ($urandom_range(0, 5) == 0);
      exmem_pcsrc    = ($urandom_range(0, 6) == 0);
      exmem_jtopc    = ($urandom_range(0, 9) == 0);
      dmem_ready     = ($urandom_range(0, 9) < 6);
      if (!RSTn) model_reset();
      mid();
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (act(k) !== exp_ctl(k) || act_stall(k) !== 16'(m_stall[k]) || act_flush(k) !== 16'(m_flush[k])) begin
          failures++; $display("FAIL rand_n%0d dut%0d act=%b stall=%0d flush=%0d exp=%b stall=%0d flush=%0d",
                               n, k, act(k), act_stall(k), act_flush(k), exp_ctl(k), m_stall[k], m_flush[k]);
        end
      end
      tick();
    end
    RSTn = 1;
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_redirect();
    test_mem_wait();
    test_timeout();
    test_reset_midwait();
    test_saturate();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not complete in time");
    $fatal(1);
  end

endmodule
